down_counter_timer: RTL and testbench
=====================================

// Module: down_counter_timer
// PURPOSE
//   Synchronous, loadable 4-bit (parameterizable) down counter/timer.
//   Counts in the opposite direction to the counter block: it loads a start value, decrements to zero, and flags terminal count.
//   Used as a programmable interval timer alongside the up counter in the same stimulus environments.
//   Supports one-shot and auto-reload modes under a 3-state controller.
// PARAMETERS
//   WIDTH  4  counter width in bits; legal range 2..16
// PORTS
//   clock        input   1      rising-edge clock
//   clear        input   1      asynchronous active-high reset
//   load         input   1      load load_val into Q and start, single-cycle strobe
//   load_val     input   WIDTH  start value, sampled only when load=1
//   enable       input   1      decrement qualifier; 0 holds Q in RUN
//   auto_reload  input   1      1 = reload last load_val at terminal count; 0 = one-shot
//   Q            output  WIDTH  current count
//   tc           output  1      terminal-count pulse, exactly 1 cycle
//   busy         output  1      1 while state = RUN
//   done         output  1      1 while state = DONE (one-shot expired)
// BEHAVIOUR
//   Reset: clear=1 forces immediately, without a clock edge: Q=0, reload_reg=0, state=IDLE, tc=0, busy=0, done=0.
//     All outputs are registered. clear overrides everything, including in the middle of a count.
//   Priority on each rising edge: clear > load > count > hold.
//   States:
//     IDLE: Q holds its value. load && load_val!=0 -> Q=load_val, reload_reg=load_val, go to RUN.
//     RUN: enable=0 -> hold. enable=1 && Q>1 -> Q=Q-1.
//       At Q==1 with enable=1 (terminal edge), tc=1 on the next cycle, and:
//         auto_reload=1 -> Q=reload_reg, stay in RUN.
//         auto_reload=0 -> Q=0, go to DONE.
//     DONE: Q=0, done=1. Only load (or clear) leaves this state.
//   load in any state: load_val!=0 -> Q=load_val, reload_reg=load_val, state=RUN, tc=0.
//     load_val==0 -> Q=0, reload_reg=0, state=IDLE, tc stays 0 (no spurious terminal count).
//   Simultaneous load with a terminal edge: load wins; no tc pulse is emitted.
//   auto_reload is sampled only at the terminal edge; changing it mid-count has no other effect.
//   tc is high for exactly one cycle per terminal edge and is never asserted in IDLE.
//   Back-to-back reloads with load_val=1 and enable=1 assert tc every cycle, with Q staying at 1.
//   Arithmetic is modulo 2^WIDTH, but Q never wraps from 0 to all-ones: the counter never decrements from 0.
//   Latency: load -> Q valid 1 cycle. Terminal edge -> tc 1 cycle.
//     A load of N with enable held high produces tc N cycles after the load edge.
//   busy = (state==RUN). done = (state==DONE). Both are mutually exclusive.
// TESTING
//   1. Hold clear=1 then release; pulse load with load_val=4'd5, auto_reload=0, enable=1.
//      -> Q = 5,4,3,2,1,0. tc high only in the cycle Q=0. done=1 from then on; busy=0.
//   2. load_val=4'd3, auto_reload=1, enable=1 for 10 cycles.
//      -> Q = 3,2,1,3,2,1,3,... with tc pulsing on each Q=3 after a 1. busy stays 1.
//   3. load_val=4'd6, enable toggled 1,0,1,0,...
//      -> Q decrements only on enabled cycles. tc arrives 12 cycles after the load.
//   4. Raise clear asynchronously between edges while Q=4'd7 in RUN.
//      -> Q=0, busy=0, tc=0 immediately. Count stays IDLE after release until a load.
//   5. Pulse load with load_val=4'd9 in the same cycle as the Q==1 terminal edge.
//      -> Q=9, no tc pulse, busy=1.
//   6. load_val=4'd0 -> Q=0, state IDLE, tc never asserted.
//      Then load_val=4'hF with WIDTH=4 -> tc 15 cycles later, with no wrap past 0.

Source files
------------

// File: rtl/down_counter_timer.sv
// -----------------------------------------------------------------------------
// down_counter_timer
//   Loadable down counter used as a programmable interval timer. A load
//   captures a start value and starts the count. The counter decrements to
//   zero and pulses tc for one cycle at terminal count. It then either
//   reloads the last start value (auto-reload) or parks in DONE (one-shot).
//
// Parameters
//   WIDTH        counter width in bits (legal range 2..16)
//
// Ports
//   clock        in   rising-edge clock
//   clear        in   asynchronous active-high reset
//   load         in   single-cycle strobe: load load_val into Q and start
//   load_val     in   start value, sampled only while load=1
//   enable       in   decrement qualifier in RUN (0 holds Q)
//   auto_reload  in   1 = reload at terminal count, 0 = one-shot
//   Q            out  current count
//   tc           out  terminal-count pulse, exactly one cycle wide
//   busy         out  state == RUN
//   done         out  state == DONE (one-shot expired)
// -----------------------------------------------------------------------------
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // State register. Count, reload value and tc pulse share the same reset
  // so that clear returns the whole block to a known idle point at once.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; combinational blocks below use blocking ones.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state logic. Priority: load > count > hold.
  always_comb begin
    // NOTE: every signal gets a default here, so no path can leave one
    // unassigned and infer a latch.
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      // A load always cancels any pending terminal count, so tc stays low
      // even when the load coincides with the terminal edge. A zero start
      // value parks the timer in IDLE rather than firing immediately.
      if (load_val != '0) begin
        q_d      = load_val;
        reload_d = load_val;
        state_d  = RUN;
      end else begin
        q_d      = '0;
        reload_d = '0;
        state_d  = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          // Hold Q; tc is never raised from IDLE.
        end
        RUN: begin
          if (enable) begin
            if (q_q > ONE) begin
              q_d = q_q - ONE;
            end else if (q_q == ONE) begin
              // Terminal edge: this is the only point auto_reload matters.
              tc_d = 1'b1;
              if (auto_reload) begin
                q_d = reload_q;
              end else begin
                q_d     = '0;
                state_d = DONE;
              end
            end
            // q_q == 0 cannot occur in RUN; holding avoids a wrap to all-ones.
          end
        end
        DONE: begin
          q_d = '0;
        end
        default: begin
          state_d = IDLE;
          q_d     = '0;
        end
      endcase
    end
  end

  // Output decode. Every output comes straight from a flop or from a
  // compare on the state register, so none depends on the current inputs.
  always_comb begin
    Q    = q_q;
    tc   = tc_q;
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// -----------------------------------------------------------------------------
// tb_down_counter_timer
//   Table-driven bench for down_counter_timer (WIDTH=4). Each vector holds the
//   inputs for one clock edge and the outputs expected just after it. The
//   expectations go into a scoreboard queue when the inputs are driven and
//   come back out for comparison after the edge. The asynchronous clear is
//   exercised with a hand-written sequence between edges.
// -----------------------------------------------------------------------------
module tb_down_counter_timer;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         enable = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] Q;
  logic         tc;
  logic         busy;
  logic         done;

  down_counter_timer #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .load        (load),
    .load_val    (load_val),
    .enable      (enable),
    .auto_reload (auto_reload),
    .Q           (Q),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    string        name;
    logic         ld;
    logic [W-1:0] lv;
    logic         en;
    logic         ar;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;

  task automatic check(input string name, input logic [W-1:0] exp_q,
                       input logic exp_tc, input logic exp_busy,
                       input logic exp_done);
    vectors_applied++;
    if ({Q, tc, busy, done} !== {exp_q, exp_tc, exp_busy, exp_done}) begin
      miscompares++;
      $display("FAIL %s: got Q=%0h tc=%0b busy=%0b done=%0b, want Q=%0h tc=%0b busy=%0b done=%0b",
               name, Q, tc, busy, done, exp_q, exp_tc, exp_busy, exp_done);
    end
  endtask

  task automatic add(input string name, input logic ld, input logic [W-1:0] lv,
                     input logic en, input logic ar, input logic [W-1:0] q,
                     input logic t, input logic b, input logic d);
    vec_t v;
    v.name = name; v.ld = ld; v.lv = lv; v.en = en; v.ar = ar;
    v.q = q; v.tc = t; v.busy = b; v.done = d;
    vecs.push_back(v);
  endtask

  // Drive each vector between edges, push its expectation, then pop and
  // compare 2 time units after the rising edge.
  task automatic run_vecs();
    exp_t e;
    exp_t got;
    foreach (vecs[i]) begin
      load        = vecs[i].ld;
      load_val    = vecs[i].lv;
      enable      = vecs[i].en;
      auto_reload = vecs[i].ar;
      e.name = $sformatf("%s[%0d]", vecs[i].name, i);
      e.q    = vecs[i].q;
      e.tc   = vecs[i].tc;
      e.busy = vecs[i].busy;
      e.done = vecs[i].done;
      sb.push_back(e);
      @(posedge clock);
      #2;
      got = sb.pop_front();
      check(got.name, got.q, got.tc, got.busy, got.done);
    end
    load = 1'b0;
    vecs.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset: asynchronous, checked without any clock edge ----
    #2 clear = 1'b1;
    #1 check("reset_async", '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1 check("reset_held", '0, 1'b0, 1'b0, 1'b0);
    @(negedge clock) clear = 1'b0;

    // ---- one-shot count from 5 ----
    add("oneshot", 1, 4'd5, 1, 0, 4'd5, 0, 1, 0);
    add("oneshot", 0, 4'd0, 1, 0, 4'd4, 0, 1, 0);
    add("oneshot", 0, 4'd0, 1, 0, 4'd3, 0, 1, 0);
    add("oneshot", 0, 4'd0, 1, 0, 4'd2, 0, 1, 0);
    add("oneshot", 0, 4'd0, 1, 0, 4'd1, 0, 1, 0);
    add("oneshot", 0, 4'd0, 1, 0, 4'd0, 1, 0, 1);
    add("oneshot", 0, 4'd0, 1, 0, 4'd0, 0, 0, 1);
    add("oneshot", 0, 4'd0, 1, 1, 4'd0, 0, 0, 1);

    // ---- auto-reload from 3 for 10 cycles ----
    add("reload", 1, 4'd3, 1, 1, 4'd3, 0, 1, 0);
    for (int r = 0; r < 3; r++) begin
      add("reload", 0, 4'd0, 1, 1, 4'd2, 0, 1, 0);
      add("reload", 0, 4'd0, 1, 1, 4'd1, 0, 1, 0);
      add("reload", 0, 4'd0, 1, 1, 4'd3, 1, 1, 0);
    end
    // auto_reload low mid-count is ignored; only the terminal edge samples it
    add("ar_sample", 0, 4'd0, 1, 0, 4'd2, 0, 1, 0);
    add("ar_sample", 0, 4'd0, 1, 0, 4'd1, 0, 1, 0);
    add("ar_sample", 0, 4'd0, 1, 1, 4'd3, 1, 1, 0);

    // ---- back-to-back reloads of 1: tc every cycle, Q stays 1 ----
    add("reload1", 1, 4'd1, 1, 1, 4'd1, 0, 1, 0);
    add("reload1", 0, 4'd0, 1, 1, 4'd1, 1, 1, 0);
    add("reload1", 0, 4'd0, 1, 1, 4'd1, 1, 1, 0);
    add("reload1", 0, 4'd0, 1, 1, 4'd1, 1, 1, 0);
    add("reload1", 0, 4'd0, 0, 1, 4'd1, 0, 1, 0);

    // ---- enable toggling: load 6, tc 12 edges after the load ----
    add("toggle", 1, 4'd6, 1, 0, 4'd6, 0, 1, 0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 12)
        add("toggle", 0, 4'd0, 1, 0, 4'd0, 1, 0, 1);
      else if ((k % 2) == 0)
        add("toggle", 0, 4'd0, 1, 0, W'(6 - k / 2), 0, 1, 0);
      else
        add("toggle", 0, 4'd0, 0, 0, W'(6 - k / 2), 0, 1, 0);
    end

    // ---- start of the asynchronous-clear case: load 7 and hold ----
    add("pre_clear", 1, 4'd7, 0, 0, 4'd7, 0, 1, 0);
    add("pre_clear", 0, 4'd0, 0, 0, 4'd7, 0, 1, 0);
    run_vecs();

    // Raise clear between edges while Q=7 in RUN.
    #1 clear = 1'b1;
    #1 check("clear_midcount", '0, 1'b0, 1'b0, 1'b0);
    @(negedge clock) clear = 1'b0;

    // ---- stays IDLE after release until a load ----
    add("post_clear", 0, 4'd0, 1, 0, 4'd0, 0, 0, 0);
    add("post_clear", 0, 4'd0, 1, 1, 4'd0, 0, 0, 0);

    // ---- load coinciding with the terminal edge: load wins, no tc ----
    add("load_at_tc", 1, 4'd2, 1, 0, 4'd2, 0, 1, 0);
    add("load_at_tc", 0, 4'd0, 1, 0, 4'd1, 0, 1, 0);
    add("load_at_tc", 1, 4'd9, 1, 0, 4'd9, 0, 1, 0);
    add("load_at_tc", 0, 4'd0, 0, 0, 4'd9, 0, 1, 0);

    // ---- load of zero: IDLE, no tc ----
    add("load_zero", 1, 4'd0, 1, 1, 4'd0, 0, 0, 0);
    add("load_zero", 0, 4'd0, 1, 1, 4'd0, 0, 0, 0);
    add("load_zero", 0, 4'd0, 1, 1, 4'd0, 0, 0, 0);

    // ---- full-scale load of 15: tc 15 edges later, no wrap past 0 ----
    add("load_max", 1, 4'hF, 1, 0, 4'hF, 0, 1, 0);
    for (int k = 14; k >= 1; k--)
      add("load_max", 0, 4'd0, 1, 0, W'(k), 0, 1, 0);
    add("load_max", 0, 4'd0, 1, 0, 4'd0, 1, 0, 1);
    add("load_max", 0, 4'd0, 1, 0, 4'd0, 0, 0, 1);
    add("load_max", 0, 4'd0, 1, 0, 4'd0, 0, 0, 1);
    run_vecs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
